// File: rtl/ladybird_iram_arbiter.sv
// Two-requester arbiter for the instruction-RAM secondary port with in-order read-response steering via a tag FIFO.
// Optional round-robin arbitration is enabled by defining LADYBIRD_IRAM_ARB_RR_EN (fixed priority to port 0 otherwise).
module ladybird_iram_arbiter #(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 4,
    localparam int TAG_DEPTH_W    = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    // requester 0: core instruction fetch
    input  logic                   i_s0_req,
    output logic                   o_s0_gnt,
    input  logic [XLEN-1:0]        i_s0_addr,
    input  logic [3:0]             i_s0_wstrb,
    input  logic [XLEN-1:0]        i_s0_wdata,
    output logic [XLEN-1:0]        o_s0_rdata,
    output logic                   o_s0_data_gnt,
    // requester 1: loader / debug
    input  logic                   i_s1_req,
    output logic                   o_s1_gnt,
    input  logic [XLEN-1:0]        i_s1_addr,
    input  logic [3:0]             i_s1_wstrb,
    input  logic [XLEN-1:0]        i_s1_wdata,
    output logic [XLEN-1:0]        o_s1_rdata,
    output logic                   o_s1_data_gnt,
    // RAM side
    output logic                   o_m_req,
    input  logic                   i_m_gnt,
    output logic [XLEN-1:0]        o_m_addr,
    output logic [3:0]             o_m_wstrb,
    output logic [XLEN-1:0]        o_m_wdata,
    input  logic [XLEN-1:0]        i_m_rdata,
    input  logic                   i_m_data_gnt,
    // status
    output logic [TAG_DEPTH_W-1:0] o_outstanding,
    output logic                   o_err_orphan
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);

    logic [MAX_OUTSTANDING-1:0] r_tag;
    logic [PTR_W-1:0]           r_wptr;
    logic [PTR_W-1:0]           r_rptr;
    logic [TAG_DEPTH_W-1:0]     r_count;
    logic                       r_err_orphan;

    logic w_full;
    logic w_empty;
    logic w_s0_elig;
    logic w_s1_elig;
    logic w_any;
    logic w_sel;
    logic w_xfer;
    logic w_is_wr;
    logic w_push;
    logic w_pop;
    logic w_orphan;
    logic w_head;

    // Full is judged on the registered count only, so a same-cycle pop never frees a slot for a read.
    assign w_full    = (r_count == TAG_DEPTH_W'(MAX_OUTSTANDING));
    assign w_empty   = (r_count == '0);
    assign w_s0_elig = i_s0_req & ((|i_s0_wstrb) | ~w_full);
    assign w_s1_elig = i_s1_req & ((|i_s1_wstrb) | ~w_full);
    assign w_any     = w_s0_elig | w_s1_elig;

`ifdef LADYBIRD_IRAM_ARB_RR_EN
    logic r_last;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_last <= 1'b1;
        end else if (w_xfer) begin
            r_last <= w_sel;
        end
    end

    assign w_sel = w_s1_elig & (~w_s0_elig | ~r_last);
`else
    assign w_sel = w_s1_elig & ~w_s0_elig;
`endif

    assign o_m_req   = i_nrst & w_any;
    assign o_m_addr  = w_sel ? i_s1_addr  : i_s0_addr;
    assign o_m_wstrb = w_sel ? i_s1_wstrb : i_s0_wstrb;
    assign o_s0_gnt  = o_m_req & ~w_sel & i_m_gnt;
    assign o_s1_gnt  = o_m_req &  w_sel & i_m_gnt;

    assign w_xfer    = o_m_req & i_m_gnt;
    assign w_is_wr   = |o_m_wstrb;
    assign w_push    = w_xfer & ~w_is_wr;
    assign w_pop     = i_nrst & i_m_data_gnt & ~w_empty;
    assign w_orphan  = i_m_data_gnt & w_empty;
    assign w_head    = r_tag[r_rptr];

    assign o_m_wdata = (w_xfer & w_is_wr) ? (w_sel ? i_s1_wdata : i_s0_wdata) : 'z;

    // Responses pass straight through to whichever port owns the FIFO head.
    assign o_s0_data_gnt = w_pop & ~w_head;
    assign o_s1_data_gnt = w_pop &  w_head;
    assign o_s0_rdata    = o_s0_data_gnt ? i_m_rdata : 'z;
    assign o_s1_rdata    = o_s1_data_gnt ? i_m_rdata : 'z;

    assign o_outstanding = r_count;
    assign o_err_orphan  = r_err_orphan;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_tag        <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_push) begin
                r_tag[r_wptr] <= w_sel;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= r_count + TAG_DEPTH_W'(w_push) - TAG_DEPTH_W'(w_pop);
            if (w_orphan) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

endmodule
